// File: rtl/route_lookup_arb_pkg.sv
// route_lookup_arb_pkg: widths, direction codes and helpers shared by the router,
// the routing table and the lookup arbiter.
package route_lookup_arb_pkg;
    localparam int ADDR_BITS = 4;
    localparam int BITS_DIR  = 3;
    localparam int NUM_NODES = 16;

    typedef enum logic [BITS_DIR-1:0] {
        DIR_NORTH = 3'd0,
        DIR_EAST  = 3'd1,
        DIR_SOUTH = 3'd2,
        DIR_WEST  = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;

    function automatic int next_port(input int w, input int n);
        return (w == n - 1) ? 0 : w + 1;
    endfunction
endpackage

// File: rtl/route_lookup_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible port at or after ptr.
module rr_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] elig,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PW-1:0]        win
);
    logic [PW-1:0] k;

    // Scan furthest offset first so the closest eligible port to ptr wins.
    always_comb begin
        gnt = '0;
        win = '0;
        k   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            k = PW'((int'(ptr) + i) % NUM_PORTS);
            if (elig[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                win    = k;
            end
        end
    end
endmodule

// File: rtl/route_lookup_arb.sv
// route_lookup_arb: shares the routing table read port among input ports; grant in
// stage A, capture of the table output and one-hot ack in stage B.
module route_lookup_arb #(
    parameter int NUM_PORTS = 5,
    parameter int ADDR_BITS = route_lookup_arb_pkg::ADDR_BITS,
    parameter int DIR_BITS  = route_lookup_arb_pkg::BITS_DIR
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] req_addr,
    output logic [NUM_PORTS-1:0]           ack,
    output logic [DIR_BITS-1:0]            rsp_dir,
    output logic [ADDR_BITS-1:0]           table_addr,
    input  logic [DIR_BITS-1:0]            table_data
);
    import route_lookup_arb_pkg::*;

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] elig, gnt, gnt_q, ack_q, ack_d;
    logic [PW-1:0]        win, ptr_q, ptr_d;
    logic [ADDR_BITS-1:0] table_addr_q, table_addr_d;
    logic [DIR_BITS-1:0]  rsp_dir_q, rsp_dir_d;
    logic                 lkp_vld_q, lkp_vld_d;

    // A port with a lookup in flight or being acknowledged is not re-granted.
    assign elig = req & ~(gnt_q | ack_q);

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_arb (
        .elig(elig),
        .ptr (ptr_q),
        .gnt (gnt),
        .win (win)
    );

    always_comb begin
        lkp_vld_d    = |elig;
        ptr_d        = lkp_vld_d ? PW'(next_port(int'(win), NUM_PORTS)) : ptr_q;
        table_addr_d = lkp_vld_d ? req_addr[int'(win)*ADDR_BITS +: ADDR_BITS] : table_addr_q;
        ack_d        = lkp_vld_q ? gnt_q : '0;
        rsp_dir_d    = lkp_vld_q ? table_data : rsp_dir_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q        <= '0;
            lkp_vld_q    <= 1'b0;
            ptr_q        <= '0;
            table_addr_q <= '0;
            ack_q        <= '0;
            rsp_dir_q    <= '0;
        end else begin
            gnt_q        <= gnt;
            lkp_vld_q    <= lkp_vld_d;
            ptr_q        <= ptr_d;
            table_addr_q <= table_addr_d;
            ack_q        <= ack_d;
            rsp_dir_q    <= rsp_dir_d;
        end
    end

    assign ack        = ack_q;
    assign rsp_dir    = rsp_dir_q;
    assign table_addr = table_addr_q;
endmodule

// File: tb/tb_route_lookup_arb.sv
// tb_route_lookup_arb: directed checks of the lookup arbiter against a node-0
// XY routing table on a 4x4 mesh.
module tb_route_lookup_arb;
    import route_lookup_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  req = '0;
    logic [19:0] req_addr = '0;
    logic [4:0]  ack;
    logic [2:0]  rsp_dir;
    logic [3:0]  table_addr;
    logic [2:0]  table_data;
    int          total = 0;
    int          bad = 0;

    route_lookup_arb dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .ack       (ack),
        .rsp_dir   (rsp_dir),
        .table_addr(table_addr),
        .table_data(table_data)
    );

    always #5 clk = ~clk;

    // Node 0 sits at x=0,y=0; XY routing resolves x before y.
    always_comb begin
        table_data = DIR_LOCAL;
        if (table_addr[1:0] != 2'd0)      table_data = DIR_EAST;
        else if (table_addr[3:2] != 2'd0) table_data = DIR_SOUTH;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic set_addr(input int p, input logic [3:0] a);
        req_addr[p*4 +: 4] = a;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL reset_ack got=%b exp=00000", ack); end
        total++; if (rsp_dir !== 3'd0) begin bad++; $display("FAIL reset_rsp got=%0d exp=0", rsp_dir); end
        total++; if (table_addr !== 4'd0) begin bad++; $display("FAIL reset_taddr got=%0d exp=0", table_addr); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        set_addr(0, 4'd4);
        req = 5'b00001;
        step();
        total++; if (table_addr !== 4'd4) begin bad++; $display("FAIL single_taddr got=%0d exp=4", table_addr); end
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL single_early_ack got=%b exp=00000", ack); end
        step();
        total++; if (ack !== 5'b00001) begin bad++; $display("FAIL single_ack got=%b exp=00001", ack); end
        total++; if (rsp_dir !== 3'd2) begin bad++; $display("FAIL single_rsp got=%0d exp=2", rsp_dir); end
        req = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (ack !== 5'b0) begin bad++; $display("FAIL single_no_ack cyc=%0d got=%b exp=00000", k, ack); end
        end
    endtask

    task automatic test_all_ports();
        logic [2:0] edir [5] = '{3'd4, 3'd1, 3'd2, 3'd1, 3'd2};
        logic [4:0] eack;
        pulse_reset();
        set_addr(0, 4'd0);
        set_addr(1, 4'd1);
        set_addr(2, 4'd4);
        set_addr(3, 4'd5);
        set_addr(4, 4'd12);
        req = 5'b11111;
        for (int k = 1; k <= 12; k++) begin
            step();
            eack = (k >= 2) ? 5'(1 << ((k - 2) % 5)) : 5'b0;
            total++; if (ack !== eack) begin bad++; $display("FAIL all_ack edge=%0d got=%b exp=%b", k, ack, eack); end
            if (k >= 2) begin
                total++;
                if (rsp_dir !== edir[(k - 2) % 5]) begin
                    bad++; $display("FAIL all_rsp edge=%0d got=%0d exp=%0d", k, rsp_dir, edir[(k - 2) % 5]);
                end
            end
        end
        req = '0;
        step();
        step();
        step();
    endtask

    task automatic test_back_to_back_hold();
        pulse_reset();
        set_addr(2, 4'd1);
        req = 5'b00100;
        step();
        total++; if (table_addr !== 4'd1) begin bad++; $display("FAIL hold_taddr1 got=%0d exp=1", table_addr); end
        step();
        total++; if (ack !== 5'b00100) begin bad++; $display("FAIL hold_ack1 got=%b exp=00100", ack); end
        total++; if (rsp_dir !== 3'd1) begin bad++; $display("FAIL hold_rsp1 got=%0d exp=1", rsp_dir); end
        set_addr(2, 4'd12);
        step();
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL hold_gap1 got=%b exp=00000", ack); end
        step();
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL hold_gap2 got=%b exp=00000", ack); end
        total++; if (table_addr !== 4'd12) begin bad++; $display("FAIL hold_taddr2 got=%0d exp=12", table_addr); end
        step();
        total++; if (ack !== 5'b00100) begin bad++; $display("FAIL hold_ack2 got=%b exp=00100", ack); end
        total++; if (rsp_dir !== 3'd2) begin bad++; $display("FAIL hold_rsp2 got=%0d exp=2", rsp_dir); end
        req = '0;
        step();
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL hold_after got=%b exp=00000", ack); end
    endtask

    task automatic test_ptr_wrap();
        pulse_reset();
        set_addr(3, 4'd5);
        set_addr(4, 4'd12);
        set_addr(0, 4'd1);
        req = 5'b01000;
        step();
        total++; if (table_addr !== 4'd5) begin bad++; $display("FAIL wrap_taddr3 got=%0d exp=5", table_addr); end
        req = 5'b11001;
        step();
        total++; if (ack !== 5'b01000) begin bad++; $display("FAIL wrap_ack3 got=%b exp=01000", ack); end
        total++; if (rsp_dir !== 3'd1) begin bad++; $display("FAIL wrap_rsp3 got=%0d exp=1", rsp_dir); end
        total++; if (table_addr !== 4'd12) begin bad++; $display("FAIL wrap_taddr4 got=%0d exp=12", table_addr); end
        req = 5'b10001;
        step();
        total++; if (ack !== 5'b10000) begin bad++; $display("FAIL wrap_ack4 got=%b exp=10000", ack); end
        total++; if (rsp_dir !== 3'd2) begin bad++; $display("FAIL wrap_rsp4 got=%0d exp=2", rsp_dir); end
        total++; if (table_addr !== 4'd1) begin bad++; $display("FAIL wrap_taddr0 got=%0d exp=1", table_addr); end
        req = 5'b00001;
        step();
        total++; if (ack !== 5'b00001) begin bad++; $display("FAIL wrap_ack0 got=%b exp=00001", ack); end
        total++; if (rsp_dir !== 3'd1) begin bad++; $display("FAIL wrap_rsp0 got=%0d exp=1", rsp_dir); end
        req = '0;
        step();
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL wrap_after got=%b exp=00000", ack); end
    endtask

    task automatic test_async_reset();
        set_addr(0, 4'd4);
        set_addr(1, 4'd12);
        req = 5'b00001;
        step();
        total++; if (table_addr !== 4'd4) begin bad++; $display("FAIL areset_pre_taddr got=%0d exp=4", table_addr); end
        #2;
        reset = 1'b1;
        req = 5'b00011;
        #1;
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL areset_ack got=%b exp=00000", ack); end
        total++; if (table_addr !== 4'd0) begin bad++; $display("FAIL areset_taddr got=%0d exp=0", table_addr); end
        total++; if (rsp_dir !== 3'd0) begin bad++; $display("FAIL areset_rsp got=%0d exp=0", rsp_dir); end
        step();
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL areset_held_ack got=%b exp=00000", ack); end
        #2;
        reset = 1'b0;
        step();
        total++; if (ack !== 5'b0) begin bad++; $display("FAIL areset_discard got=%b exp=00000", ack); end
        total++; if (table_addr !== 4'd4) begin bad++; $display("FAIL areset_regrant_taddr got=%0d exp=4", table_addr); end
        step();
        total++; if (ack !== 5'b00001) begin bad++; $display("FAIL areset_ack0 got=%b exp=00001", ack); end
        total++; if (rsp_dir !== 3'd2) begin bad++; $display("FAIL areset_rsp0 got=%0d exp=2", rsp_dir); end
        total++; if (table_addr !== 4'd12) begin bad++; $display("FAIL areset_taddr1 got=%0d exp=12", table_addr); end
        req = 5'b00010;
        step();
        total++; if (ack !== 5'b00010) begin bad++; $display("FAIL areset_ack1 got=%b exp=00010", ack); end
        total++; if (rsp_dir !== 3'd2) begin bad++; $display("FAIL areset_rsp1 got=%0d exp=2", rsp_dir); end
        req = '0;
        step();
        step();
    endtask

    task automatic test_idle();
        for (int k = 0; k < 10; k++) begin
            step();
            total++; if (ack !== 5'b0) begin bad++; $display("FAIL idle_ack cyc=%0d got=%b exp=00000", k, ack); end
            total++; if (table_addr !== 4'd12) begin bad++; $display("FAIL idle_taddr cyc=%0d got=%0d exp=12", k, table_addr); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_ports();
        test_back_to_back_hold();
        test_ptr_wrap();
        test_async_reset();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
